// File: rtl/sha256_round_sequencer.sv
// Control sequencer for one SHA-256 compression over a shared round datapath.
// Optional perf counters (blocks_done, stall_cycles) when SHA256_SEQ_PERF_EN is defined.
module sha256_round_sequencer #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             first_block,
  input  logic             abort,
  input  logic             stall,
  output logic [CNT_W-1:0] cnt,
  output logic             init_en,
  output logic             h_sel_iv,
  output logic             round_en,
  output logic             w_from_msg,
  output logic             final_en,
  output logic             done_valid,
  input  logic             done_ready
`ifdef SHA256_SEQ_PERF_EN
  ,
  output logic [15:0]      blocks_done,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t state;
  logic   accept;

  assign accept = start_valid & start_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      h_sel_iv <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            h_sel_iv <= first_block;
            state    <= S_INIT;
          end
        end
        S_INIT: begin
          cnt   <= '0;
          state <= abort ? S_IDLE : S_ROUND;
        end
        S_ROUND: begin
          if (abort) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (!stall) begin
            // last round wraps the index explicitly rather than overflowing
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_FINAL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_FINAL: begin
          cnt   <= '0;
          state <= abort ? S_IDLE : S_DONE;
        end
        S_DONE: begin
          cnt <= '0;
          if (abort || done_ready) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Strobes are gated by abort in the same cycle so no half round is committed.
  assign start_ready = (state == S_IDLE);
  assign done_valid  = (state == S_DONE);
  assign init_en     = (state == S_INIT)  & ~abort;
  assign round_en    = (state == S_ROUND) & ~stall & ~abort;
  assign final_en    = (state == S_FINAL) & ~abort;
  assign w_from_msg  = round_en & (32'(cnt) < 32'd16);

`ifdef SHA256_SEQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blocks_done  <= '0;
      stall_cycles <= '0;
    end else begin
      if (done_valid && done_ready && !abort) blocks_done <= blocks_done + 16'd1;
      if ((state == S_ROUND) && stall) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Scoreboard bench for sha256_round_sequencer: expected completions queued at start, checked at done.
module tb_sha256_round_sequencer;
  localparam int ROUNDS = 64;
  localparam int CNT_W  = 6;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start_valid, start_ready, first_block, abort, stall;
  logic [CNT_W-1:0] cnt;
  logic             init_en, h_sel_iv, round_en, w_from_msg, final_en;
  logic             done_valid, done_ready;
`ifdef SHA256_SEQ_PERF_EN
  logic [15:0]      blocks_done, stall_cycles;
`endif

  sha256_round_sequencer #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .first_block (first_block),
    .abort       (abort),
    .stall       (stall),
    .cnt         (cnt),
    .init_en     (init_en),
    .h_sel_iv    (h_sel_iv),
    .round_en    (round_en),
    .w_from_msg  (w_from_msg),
    .final_en    (final_en),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
`ifdef SHA256_SEQ_PERF_EN
    ,
    .blocks_done (blocks_done),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic fb;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  int   exp_hs = 0;
  int   exp_pb = 0;
  int   exp_ps = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock)
    if (reset_n && done_valid && done_ready) hs_cnt <= hs_cnt + 1;

  always @(negedge clock) begin
    #2;
    chk("strobe_onehot", int'($countones({init_en, round_en, final_en}) <= 1), 1);
    chk("cnt_range", int'(cnt <= CNT_W'(ROUNDS - 1)), 1);
  end

  // Entered just after a negedge with the DUT in IDLE; start is driven in that same cycle.
  task automatic run_block(input logic fb, input int stall_at, input int stall_n,
                           input int rdy_wait, input int abort_at, input int rst_at);
    int   cyc, r, stalled, held;
    logic st;
    exp_t e;
    if (abort_at < 0 && rst_at < 0) sb.push_back('{fb: fb, lat: 67 + stall_n});
    start_valid = 1'b1; first_block = fb; abort = (abort_at >= 0);
    #1;
    chk("start_ready", start_ready, 1);
    @(negedge clock);
    start_valid = 1'b0; first_block = ~fb; abort = 1'b0;
    #1;
    cyc = 1;
    chk("init_en", init_en, 1);
    chk("init_cnt", cnt, 0);
    chk("init_hsel", h_sel_iv, fb);
    chk("init_rnd", round_en, 0);
    r = 0; stalled = 0;
    while (r < ROUNDS) begin
      @(negedge clock);
      cyc++;
      st = (r == stall_at) && (stalled < stall_n);
      stall = st;
      if (r == abort_at) abort = 1'b1;
      #1;
      if (r == abort_at) begin
        chk("abort_rnd", round_en, 0);
        chk("abort_fin", final_en, 0);
        chk("abort_w", w_from_msg, 0);
        @(negedge clock);
        abort = 1'b0; stall = 1'b0;
        #1;
        chk("abort_idle", start_ready, 1);
        chk("abort_cnt", cnt, 0);
        chk("abort_dv", done_valid, 0);
        return;
      end
      chk("rnd_en", round_en, int'(!st));
      chk("rnd_cnt", cnt, r);
      chk("rnd_w", w_from_msg, int'(!st && r < 16));
      chk("rnd_init", init_en, 0);
      if (r == rst_at && !st) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_sr", start_ready, 1);
        chk("rst_cnt", cnt, 0);
        chk("rst_rnd", round_en, 0);
        chk("rst_hsel", h_sel_iv, 0);
        chk("rst_dv", done_valid, 0);
        exp_pb = 0; exp_ps = 0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_rel_sr", start_ready, 1);
        return;
      end
      if (st) begin
        stalled++;
        exp_ps++;
      end else begin
        r++;
      end
    end
    @(negedge clock);
    stall = 1'b1;
    cyc++;
    #1;
    chk("fin_en", final_en, 1);
    chk("fin_rnd", round_en, 0);
    chk("fin_cnt", cnt, 0);
    held = 0;
    for (int k = 0; k < 20 && held == 0; k++) begin
      @(negedge clock);
      stall = 1'b0;
      cyc++;
      #1;
      if (done_valid) held = 1;
    end
    if (held == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("done_lat", cyc, e.lat);
      chk("done_hsel", h_sel_iv, e.fb);
    end
    chk("done_sr", start_ready, 0);
    done_ready = (rdy_wait == 0);
    while (!done_ready) begin
      @(negedge clock);
      #1;
      chk("done_hold_v", done_valid, 1);
      chk("done_hold_sr", start_ready, 0);
      held++;
      if (held > rdy_wait) done_ready = 1'b1;
    end
    chk("done_held", held, rdy_wait + 1);
    @(negedge clock);
    done_ready = 1'b0;
    exp_hs++; exp_pb++;
    #1;
    chk("post_dv", done_valid, 0);
    chk("post_sr", start_ready, 1);
    chk("post_cnt", cnt, 0);
  endtask

  initial begin
    reset_n = 1'b0; start_valid = 1'b0; first_block = 1'b0;
    abort = 1'b0; stall = 1'b0; done_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_cnt0", cnt, 0);
    chk("rst_hsel0", h_sel_iv, 0);
    chk("rst_strobes", int'({init_en, round_en, final_en, done_valid}), 0);
`ifdef SHA256_SEQ_PERF_EN
    chk("rst_pb", blocks_done, 0);
    chk("rst_ps", stall_cycles, 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    run_block(1'b1, -1, 0, 0, -1, -1);   // plain block from IV
    run_block(1'b1, -1, 0, 0, -1, 33);   // async reset mid-round
    run_block(1'b1, -1, 0, 0, -1, -1);   // clean block after reset
    run_block(1'b1, 20, 3, 5, -1, -1);   // stall at cnt 20, done back-pressure
    run_block(1'b0, -1, 0, 0, -1, -1);   // immediate restart from previous digest
    run_block(1'b1, 10, 1, 0, 40, -1);   // abort at cnt 40 (also asserted with start)
    run_block(1'b0, 5, 2, 1, -1, -1);
    @(negedge clock);
    #1;
    chk("handshakes", hs_cnt, exp_hs);
    chk("sb_drain", sb.size(), 0);
`ifdef SHA256_SEQ_PERF_EN
    chk("perf_blocks", blocks_done, exp_pb);
    chk("perf_stalls", stall_cycles, exp_ps);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
